// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front end. A free-running fetch PC issues in-order
//   requests to instruction memory, in-order responses are written into a
//   DEPTH-entry {pc, instr} queue, and decode drains the queue head through
//   a valid/ready handshake. A redirect flushes the queue, retargets fetch
//   and marks every still-outstanding response to be discarded on arrival.
//
// Parameters
//   WIDTH     data/address width
//   DEPTH     queue entries and maximum outstanding requests (power of two, >= 2)
//   RESET_PC  fetch address after reset (bits [1:0] forced to zero)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_req_valid/ready/addr request channel (word-aligned address)
//   mem_resp_valid/data      in-order response channel, no back-pressure
//   redirect_valid/pc        replace the fetch stream this cycle
//   instr_valid/ready        decode handshake on the queue head
//   instr, instr_pc          head instruction and its address
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [WIDTH-1:0] mem_resp_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [CW:0]      DEPTH_W    = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_resp_pc;
    logic [WIDTH-1:0] r_q_instr [DEPTH];
    logic [WIDTH-1:0] r_q_pc    [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_drop;

    logic [CW:0]      w_credit_sum;
    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_outstanding_nxt;

    always_comb begin
        w_credit_sum  = {1'b0, r_count} + {1'b0, r_outstanding};
        mem_req_valid = !rst && !redirect_valid && (w_credit_sum < DEPTH_W);
        mem_req_addr  = r_fetch_pc;
        w_req_fire    = mem_req_valid && mem_req_ready;

        instr_valid   = !rst && !redirect_valid && (r_count != '0);
        instr         = r_q_instr[r_rd_ptr];
        instr_pc      = r_q_pc[r_rd_ptr];
        w_pop         = instr_valid && instr_ready;

        // A response is kept only when nothing is pending discard; redirect
        // cycles never push because the queue is being flushed.
        w_push        = mem_resp_valid && (r_drop == '0) && !redirect_valid;

        // Requests are blocked during redirect, so in that cycle this is
        // exactly outstanding minus an arriving response: the new drop count.
        w_outstanding_nxt = r_outstanding;
        case ({w_req_fire, mem_resp_valid})
            2'b10:   w_outstanding_nxt = r_outstanding + CW'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - CW'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC & ALIGN_MASK;
            r_resp_pc     <= RESET_PC & ALIGN_MASK;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= redirect_pc & ALIGN_MASK;
            r_resp_pc     <= redirect_pc & ALIGN_MASK;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_outstanding_nxt;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if (mem_resp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + PC_STEP;
                r_wr_ptr  <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Queue payload needs no reset; entries beyond count are never observed.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_instr[r_wr_ptr] <= mem_resp_data;
            r_q_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned W   = 32;
    localparam int unsigned D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle vector table ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    // ---------------- memory model + scoreboard ----------------
    int          lat = 1;
    int          cyc = 0;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    int          pops = 0;
    int          accepts = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Sample at negedge, then advance to posedge+1 and drive the response.
    task automatic clk_step();
        @(negedge clk);
        if (mem_req_valid) begin
            chk32("req_addr", mem_req_addr, exp_req);
            if (mem_req_ready) begin
                exp_req = exp_req + 32'd4;
                accepts++;
                q_addr.push_back(mem_req_addr);
                q_due.push_back(cyc + lat);
            end
        end
        if (instr_valid && instr_ready) begin
            chk32("instr_pc", instr_pc, exp_pc);
            chk32("instr", instr, mdata(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (q_due.size() != 0 && q_due[0] <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mdata(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (n) clk_step();
        rst = 1'b0;
        exp_req = RPC;
        exp_pc  = RPC;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        chk1("redir_req_valid", mem_req_valid, 1'b0);
        chk1("redir_instr_valid", instr_valid, 1'b0);
        exp_req = pc & 32'hFFFF_FFFC;
        exp_pc  = pc & 32'hFFFF_FFFC;
        clk_step();
        redirect_valid = 1'b0;
    endtask

    task automatic run_until_pops(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (pops < target && k < budget) begin
            clk_step();
            k++;
        end
        chk1(name, pops >= target, 1'b1);
    endtask

    initial begin
        //           rst rdy rv  rd            redir rpc           ir   e_rv e_addr         e_iv e_instr        e_pc
        tbl[0]  = '{Y, N, N, 32'h0,          N, 32'h0,          N,  N, 32'h0,          N, 32'h0,          32'h0};
        tbl[1]  = '{N, Y, N, 32'h0,          N, 32'h0,          N,  Y, 32'h0000_0100,  N, 32'h0,          32'h0};
        tbl[2]  = '{N, Y, Y, 32'hAAAA_0100,  N, 32'h0,          N,  Y, 32'h0000_0104,  N, 32'h0,          32'h0};
        tbl[3]  = '{N, N, Y, 32'hAAAA_0104,  N, 32'h0,          N,  Y, 32'h0000_0108,  Y, 32'hAAAA_0100,  32'h100};
        tbl[4]  = '{N, Y, N, 32'h0,          N, 32'h0,          Y,  Y, 32'h0000_0108,  Y, 32'hAAAA_0100,  32'h100};
        tbl[5]  = '{N, Y, N, 32'h0,          N, 32'h0,          N,  Y, 32'h0000_010C,  Y, 32'hAAAA_0104,  32'h104};
        tbl[6]  = '{N, Y, N, 32'h0,          N, 32'h0,          N,  Y, 32'h0000_0110,  Y, 32'hAAAA_0104,  32'h104};
        tbl[7]  = '{N, Y, N, 32'h0,          N, 32'h0,          N,  N, 32'h0,          Y, 32'hAAAA_0104,  32'h104};
        tbl[8]  = '{N, Y, Y, 32'hAAAA_0108,  N, 32'h0,          N,  N, 32'h0,          Y, 32'hAAAA_0104,  32'h104};
        tbl[9]  = '{N, Y, Y, 32'hAAAA_010C,  Y, 32'h0000_2002,  Y,  N, 32'h0,          N, 32'h0,          32'h0};
        tbl[10] = '{N, Y, N, 32'h0,          N, 32'h0,          Y,  Y, 32'h0000_2000,  N, 32'h0,          32'h0};
        tbl[11] = '{N, N, Y, 32'hAAAA_0110,  N, 32'h0,          Y,  Y, 32'h0000_2004,  N, 32'h0,          32'h0};
        tbl[12] = '{N, N, Y, 32'hBBBB_2000,  N, 32'h0,          Y,  Y, 32'h0000_2004,  N, 32'h0,          32'h0};
        tbl[13] = '{N, N, N, 32'h0,          N, 32'h0,          Y,  Y, 32'h0000_2004,  Y, 32'hBBBB_2000,  32'h2000};
        tbl[14] = '{N, N, N, 32'h0,          N, 32'h0,          Y,  Y, 32'h0000_2004,  N, 32'h0,          32'h0};
        tbl[15] = '{N, Y, N, 32'h0,          Y, 32'hFFFF_FFF8,  N,  N, 32'h0,          N, 32'h0,          32'h0};
        tbl[16] = '{N, Y, N, 32'h0,          N, 32'h0,          N,  Y, 32'hFFFF_FFF8,  N, 32'h0,          32'h0};
        tbl[17] = '{N, Y, N, 32'h0,          N, 32'h0,          N,  Y, 32'hFFFF_FFFC,  N, 32'h0,          32'h0};
        tbl[18] = '{N, Y, N, 32'h0,          N, 32'h0,          N,  Y, 32'h0000_0000,  N, 32'h0,          32'h0};
        tbl[19] = '{N, N, Y, 32'hCCCC_FFF8,  N, 32'h0,          N,  Y, 32'h0000_0004,  N, 32'h0,          32'h0};
        tbl[20] = '{Y, N, N, 32'h0,          N, 32'h0,          N,  N, 32'h0,          N, 32'h0,          32'h0};
        tbl[21] = '{N, N, N, 32'h0,          N, 32'h0,          N,  Y, 32'h0000_0100,  N, 32'h0,          32'h0};

        for (int i = 0; i < NV; i++) begin
            rst            = tbl[i].rst;
            mem_req_ready  = tbl[i].rdy;
            mem_resp_valid = tbl[i].rv;
            mem_resp_data  = tbl[i].rd;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            instr_ready    = tbl[i].ir;
            @(negedge clk);
            chk1($sformatf("v%0d_req_valid", i), mem_req_valid, tbl[i].e_rv);
            if (tbl[i].e_rv)
                chk32($sformatf("v%0d_req_addr", i), mem_req_addr, tbl[i].e_addr);
            chk1($sformatf("v%0d_instr_valid", i), instr_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk32($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
                chk32($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].e_pc);
            end
            @(posedge clk);
            #1;
        end

        // Sequential fetch, 1-cycle memory, decode always ready.
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat = 1;
        mem_req_ready = 1'b1;
        instr_ready   = 1'b1;
        do_reset(1);
        #1;
        chk1("s1_first_req_valid", mem_req_valid, 1'b1);
        chk32("s1_first_req_addr", mem_req_addr, RPC);
        pops = 0;
        repeat (20) clk_step();
        chk32("s1_pops", 32'(pops), 32'd18);

        // Backpressure: exactly DEPTH requests then stall.
        instr_ready = 1'b0;
        do_reset(1);
        accepts = 0;
        repeat (10) clk_step();
        chk32("s2_accepts", 32'(accepts), 32'd4);
        chk1("s2_stall_req_valid", mem_req_valid, 1'b0);
        chk1("s2_full_instr_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        pops = 0;
        #1;
        chk1("s2_release_same_cycle", mem_req_valid, 1'b0);
        clk_step();
        #1;
        chk1("s2_release_next_cycle", mem_req_valid, 1'b1);
        repeat (20) clk_step();
        chk32("s2_pops", 32'(pops), 32'd21);

        // Redirect with three requests in flight, 3-cycle memory.
        lat = 3;
        instr_ready = 1'b1;
        do_reset(1);
        repeat (3) clk_step();
        do_redirect(32'h0000_2000);
        pops = 0;
        run_until_pops("s3_progress", 8, 60);

        // Misaligned redirect target.
        do_redirect(32'h0000_2002);
        pops = 0;
        run_until_pops("s4_progress", 4, 40);

        // Back-to-back redirects: only the second stream survives.
        do_redirect(32'h0000_0300);
        do_redirect(32'h0000_0400);
        pops = 0;
        run_until_pops("s5_progress", 6, 40);

        // Wrap across the top of the address space.
        do_redirect(32'hFFFF_FFF8);
        pops = 0;
        run_until_pops("s6_progress", 4, 40);

        // Reset with queue half full and requests outstanding.
        instr_ready = 1'b0;
        do_reset(1);
        repeat (5) clk_step();
        chk1("s7_pre_instr_valid", instr_valid, 1'b1);
        rst = 1'b1;
        clk_step();
        #1;
        chk1("s7_rst_instr_valid", instr_valid, 1'b0);
        chk1("s7_rst_req_valid", mem_req_valid, 1'b0);
        clk_step();
        rst = 1'b0;
        exp_req = RPC;
        exp_pc  = RPC;
        #1;
        chk1("s7_post_instr_valid", instr_valid, 1'b0);
        chk1("s7_post_req_valid", mem_req_valid, 1'b1);
        chk32("s7_post_req_addr", mem_req_addr, RPC);
        instr_ready = 1'b1;
        pops = 0;
        run_until_pops("s7_progress", 4, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
